// File: rtl/nn_fixed_point_pkg.sv
// Shared fixed-point types and helpers for the neural-net datapath blocks.
// Accumulator FSM states, accumulator sizing, round and saturate helpers.
package nn_fixed_point_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINALIZE,
    OUTPUT
  } accumulator_state_t;

  localparam int WIDE_W = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    wide_t val;
    logic  sat;
  } sat_t;

  function automatic int acc_width(
    input int vl,
    input int fpl,
    input int mb
  );
    return 2 * fpl + $clog2(vl) + $clog2(mb);
  endfunction

  // Round half up, then arithmetic shift right by frac bits.
  function automatic wide_t round_shift(
    input wide_t t,
    input int    frac
  );
    return (t + (wide_t'(1) <<< (frac - 1))) >>> frac;
  endfunction

  function automatic sat_t saturate(
    input wide_t r,
    input int    fpl
  );
    wide_t hi;
    wide_t lo;
    sat_t  s;
    hi    = (wide_t'(1) <<< (fpl - 1)) - wide_t'(1);
    lo    = ~hi;
    s.val = r;
    s.sat = 1'b0;
    if (r > hi) begin
      s.val = hi;
      s.sat = 1'b1;
    end else if (r < lo) begin
      s.val = lo;
      s.sat = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/adder_tree.sv
// Combinational signed reduction of one beat of products.
// Each product is sign-extended to the accumulator width before summing.
module adder_tree
  import nn_fixed_point_pkg::*;
#(
  parameter int VECTOR_LENGTH = 16,
  parameter int PW            = 32,
  parameter int ACC_WIDTH     = 42
) (
  input  logic [VECTOR_LENGTH*PW-1:0] products_i,
  output logic signed [ACC_WIDTH-1:0] sum_o
);

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < VECTOR_LENGTH; i++) begin
      sum_o = sum_o
            + ACC_WIDTH'(signed'(products_i[i*PW +: PW]));
    end
  end

endmodule

// File: rtl/dot_product_accumulator.sv
// Accumulates product beats per neuron, adds bias, rounds, saturates.
// Define RELU_EN to clamp negative results to zero after saturation.
module dot_product_accumulator
  import nn_fixed_point_pkg::*;
#(
  parameter int VECTOR_LENGTH        = 16,
  parameter int FIXED_POINT_LENGTH   = 16,
  parameter int FIXED_POINT_POSITION = 10,
  parameter int MAX_BEATS            = 64
) (
  input  logic                                       clk_in,
  input  logic                                       rst_in,
  input  logic [VECTOR_LENGTH*2*FIXED_POINT_LENGTH-1:0] products_in,
  input  logic [FIXED_POINT_LENGTH-1:0]              bias_in,
  input  logic                                       in_valid_in,
  input  logic                                       in_last_in,
  output logic                                       in_ready_out,
  output logic [FIXED_POINT_LENGTH-1:0]              result_out,
  output logic                                       sat_out,
  output logic                                       out_valid_out,
  input  logic                                       out_ready_in,
  output logic                                       err_out
);

  localparam int FPL   = FIXED_POINT_LENGTH;
  localparam int FRAC  = FIXED_POINT_POSITION;
  localparam int PW    = 2 * FPL;
  localparam int ACC_W = acc_width(VECTOR_LENGTH, FPL, MAX_BEATS);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  accumulator_state_t       state_q;
  logic signed [ACC_W-1:0]  beat_sum;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [FPL-1:0]    bias_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_d;
  logic                     in_ready_q;
  logic [FPL-1:0]           result_q;
  logic [FPL-1:0]           result_d;
  logic                     sat_q;
  logic                     sat_d;
  logic                     out_valid_q;
  logic                     err_q;
  logic                     accept;
  wide_t                    t_w;
  wide_t                    r_w;
  sat_t                     s_w;

  adder_tree #(
    .VECTOR_LENGTH (VECTOR_LENGTH),
    .PW            (PW),
    .ACC_WIDTH     (ACC_W)
  ) u_tree (
    .products_i (products_in),
    .sum_o      (beat_sum)
  );

  assign accept = in_valid_in && in_ready_q;

  always_comb begin
    cnt_d = (state_q == IDLE) ? CNT_W'(1) : cnt_q + 1'b1;
  end

  // Products are Q(2*FRAC); a single FRAC shift lands on the result format.
  always_comb begin
    t_w = wide_t'(acc_q) + (wide_t'(bias_q) <<< FRAC);
    r_w = round_shift(t_w, FRAC);
    s_w = saturate(r_w, FPL);
`ifdef RELU_EN
    if (s_w.val[WIDE_W-1]) begin
      result_d = '0;
      sat_d    = 1'b0;
    end else begin
      result_d = FPL'(s_w.val);
      sat_d    = s_w.sat;
    end
`else
    result_d = FPL'(s_w.val);
    sat_d    = s_w.sat;
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      bias_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      result_q    <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ACCUM: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            acc_q <= (state_q == IDLE) ? beat_sum : acc_q + beat_sum;
            if (state_q == IDLE) bias_q <= bias_in;
            cnt_q <= cnt_d;
            if (in_last_in) begin
              state_q    <= FINALIZE;
              in_ready_q <= 1'b0;
            end else if (cnt_d == CNT_W'(MAX_BEATS)) begin
              state_q    <= FINALIZE;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        FINALIZE: begin
          result_q    <= result_d;
          sat_q       <= sat_d;
          out_valid_q <= 1'b1;
          state_q     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready_in) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_out  = in_ready_q;
  assign result_out    = result_q;
  assign sat_out       = sat_q;
  assign out_valid_out = out_valid_q;
  assign err_out       = err_q;

endmodule
